// File: rtl/ysyx_pkg.sv
// Shared types and constants for the rename unit.
// Holds the default configuration and the ROB tag type. Tag 0 means
// "no producer, read the register file". Tags 1..ROB_SIZE name ROB slot+1.
package ysyx_pkg;
    localparam int DEF_RLEN     = 5;
    localparam int DEF_ROB_SIZE = 8;
    localparam int DEF_PLEN     = 128;
    localparam int DEF_TW       = $clog2(DEF_ROB_SIZE) + 1;

    typedef logic [DEF_TW-1:0] rob_tag_t;

    localparam rob_tag_t TAG_NONE = '0;
endpackage

// File: rtl/ysyx_rnu_maptable.sv
// Register-to-producer map table.
// One TW-bit entry per architectural register holds the ROB tag of its
// youngest in-flight producer, or 0 when the register file is current.
// Ports:
//   clock, reset         clock and synchronous active-low reset
//   flush                clears every entry
//   rd1_addr/rd1_tag     combinational lookup port 1
//   rd2_addr/rd2_tag     combinational lookup port 2
//   wr_en/wr_addr/wr_tag rename write (newest mapping)
//   cmt_valid/cmt_rd/cmt_dest  retirement; clears the entry if it still names cmt_dest
module ysyx_rnu_maptable
    import ysyx_pkg::*;
#(
    parameter int RLEN = DEF_RLEN,
    parameter int TW   = DEF_TW
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic [RLEN-1:0] rd1_addr,
    output logic [TW-1:0]   rd1_tag,
    input  logic [RLEN-1:0] rd2_addr,
    output logic [TW-1:0]   rd2_tag,
    input  logic            wr_en,
    input  logic [RLEN-1:0] wr_addr,
    input  logic [TW-1:0]   wr_tag,
    input  logic            cmt_valid,
    input  logic [RLEN-1:0] cmt_rd,
    input  logic [TW-1:0]   cmt_dest
);
    localparam int NREG = 2 ** RLEN;
    localparam logic [TW-1:0] NONE = TW'(TAG_NONE);

    logic [TW-1:0] map_q [NREG];
    logic          cmt_clr;

    // A producer retiring this cycle already has its value in the register
    // file, so a reader of the same tag must go to the regfile instead.
    assign rd1_tag = (rd1_addr == '0 || (cmt_valid && map_q[rd1_addr] == cmt_dest))
                     ? NONE : map_q[rd1_addr];
    assign rd2_tag = (rd2_addr == '0 || (cmt_valid && map_q[rd2_addr] == cmt_dest))
                     ? NONE : map_q[rd2_addr];

    assign cmt_clr = cmt_valid && (cmt_rd != '0) && (map_q[cmt_rd] == cmt_dest);

    // The rename write is placed after the commit clear so that a same-cycle
    // rename of the same register keeps the newer mapping.
    always_ff @(posedge clock) begin
        if (!reset || flush) begin
            for (int i = 0; i < NREG; i++) begin
                map_q[i] <= NONE;
            end
        end else begin
            if (cmt_clr) begin
                map_q[cmt_rd] <= NONE;
            end
            if (wr_en && wr_addr != '0) begin
                map_q[wr_addr] <= wr_tag;
            end
        end
    end
endmodule

// File: rtl/ysyx_rnu_rename.sv
// Rename / dispatch stage.
// Accepts one decoded instruction per cycle, allocates a ROB tag, looks up
// source producers in the map table, records rd -> tag, and presents a
// registered bundle to ROB/RS. Commit frees occupancy; flush squashes all.
// Ports:
//   clock, reset                 clock, synchronous active-low reset
//   in_valid/in_ready            decode handshake
//   in_rd, in_rd_wen, in_rs1, in_rs2, in_payload   decoded instruction
//   out_valid/out_ready          dispatch handshake
//   out_qj, out_qk, out_dest, out_rd, out_payload  registered dispatch bundle
//   cmt_valid, cmt_dest, cmt_rd  oldest-entry retirement
//   flush                        squash all in-flight state
module ysyx_rnu_rename
    import ysyx_pkg::*;
#(
    parameter int RLEN     = DEF_RLEN,
    parameter int ROB_SIZE = DEF_ROB_SIZE,
    parameter int PLEN     = DEF_PLEN,
    parameter int TW       = $clog2(ROB_SIZE) + 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [RLEN-1:0] in_rd,
    input  logic            in_rd_wen,
    input  logic [RLEN-1:0] in_rs1,
    input  logic [RLEN-1:0] in_rs2,
    input  logic [PLEN-1:0] in_payload,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [TW-1:0]   out_qj,
    output logic [TW-1:0]   out_qk,
    output logic [TW-1:0]   out_dest,
    output logic [RLEN-1:0] out_rd,
    output logic [PLEN-1:0] out_payload,
    input  logic            cmt_valid,
    input  logic [TW-1:0]   cmt_dest,
    input  logic [RLEN-1:0] cmt_rd,
    input  logic            flush
);
    localparam int PW = TW - 1;
    localparam logic [PW-1:0] TAIL_LAST = PW'(ROB_SIZE - 1);
    localparam logic [TW-1:0] COUNT_MAX = TW'(ROB_SIZE);

    logic [PW-1:0] tail_q, tail_d;
    logic [TW-1:0] count_q, count_d;
    logic [TW-1:0] new_tag;
    logic [TW-1:0] qj_tag, qk_tag;
    logic          accept;
    logic          ren_wen;

    assign in_ready = (!out_valid || out_ready) && (count_q < COUNT_MAX) && !flush;
    assign accept   = in_valid && in_ready;
    assign new_tag  = {1'b0, tail_q} + TW'(1);
    assign ren_wen  = accept && in_rd_wen;

    ysyx_rnu_maptable #(
        .RLEN (RLEN),
        .TW   (TW)
    ) u_map (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .rd1_addr  (in_rs1),
        .rd1_tag   (qj_tag),
        .rd2_addr  (in_rs2),
        .rd2_tag   (qk_tag),
        .wr_en     (ren_wen),
        .wr_addr   (in_rd),
        .wr_tag    (new_tag),
        .cmt_valid (cmt_valid),
        .cmt_rd    (cmt_rd),
        .cmt_dest  (cmt_dest)
    );

    always_comb begin
        tail_d  = tail_q;
        count_d = count_q;
        if (accept) begin
            tail_d = (tail_q == TAIL_LAST) ? '0 : tail_q + PW'(1);
        end
        if (accept && !cmt_valid) begin
            count_d = count_q + TW'(1);
        end else if (!accept && cmt_valid) begin
            count_d = count_q - TW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            tail_q      <= '0;
            count_q     <= '0;
            out_valid   <= 1'b0;
            out_qj      <= '0;
            out_qk      <= '0;
            out_dest    <= '0;
            out_rd      <= '0;
            out_payload <= '0;
        end else if (flush) begin
            tail_q    <= '0;
            count_q   <= '0;
            out_valid <= 1'b0;
        end else begin
            tail_q  <= tail_d;
            count_q <= count_d;
            if (accept) begin
                out_valid   <= 1'b1;
                out_qj      <= qj_tag;
                out_qk      <= qk_tag;
                out_dest    <= new_tag;
                out_rd      <= in_rd_wen ? in_rd : '0;
                out_payload <= in_payload;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifndef SYNTHESIS
    // The ROB can only retire something that was allocated.
    always @(posedge clock) begin
        if (reset && !flush && cmt_valid) begin
            assert (count_q != '0)
            else $error("rename: commit with empty ROB occupancy");
        end
    end
`endif
endmodule

// File: tb/tb_ysyx_rnu_rename.sv
module tb_ysyx_rnu_rename;
    import ysyx_pkg::*;

    localparam int RLEN = 5;
    localparam int ROB  = 8;
    localparam int PLEN = 128;
    localparam int TW   = 4;

    logic            clock = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [RLEN-1:0] in_rd;
    logic            in_rd_wen;
    logic [RLEN-1:0] in_rs1;
    logic [RLEN-1:0] in_rs2;
    logic [PLEN-1:0] in_payload;
    logic            out_valid;
    logic            out_ready;
    logic [TW-1:0]   out_qj;
    logic [TW-1:0]   out_qk;
    logic [TW-1:0]   out_dest;
    logic [RLEN-1:0] out_rd;
    logic [PLEN-1:0] out_payload;
    logic            cmt_valid;
    logic [TW-1:0]   cmt_dest;
    logic [RLEN-1:0] cmt_rd;
    logic            flush;

    always #5 clock = ~clock;

    ysyx_rnu_rename #(
        .RLEN(RLEN), .ROB_SIZE(ROB), .PLEN(PLEN), .TW(TW)
    ) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_rd_wen(in_rd_wen), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_payload(in_payload),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_qj(out_qj), .out_qk(out_qk), .out_dest(out_dest),
        .out_rd(out_rd), .out_payload(out_payload),
        .cmt_valid(cmt_valid), .cmt_dest(cmt_dest), .cmt_rd(cmt_rd),
        .flush(flush)
    );

    // Reference model: architectural map as plain ints, ROB as an ordered queue.
    typedef struct {
        int tag;
        int rd;
    } rob_ent_t;

    int          m_map [32];
    int          m_tail;
    rob_ent_t    m_rob [$];
    bit          e_ov;
    int          e_qj, e_qk, e_dest, e_rd;
    logic [127:0] e_pl;

    int vectors;
    int miscompares;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int look(int r, bit cv, int cd);
        if (r == 0) return 0;
        if (cv && m_map[r] == cd) return 0;
        return m_map[r];
    endfunction

    task automatic model_clear(bit full);
        for (int i = 0; i < 32; i++) m_map[i] = 0;
        m_tail = 0;
        m_rob.delete();
        e_ov = 0;
        if (full) begin
            e_qj = 0; e_qk = 0; e_dest = 0; e_rd = 0; e_pl = '0;
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", 128'(out_valid), 128'(e_ov));
        chk("out_qj", 128'(out_qj), 128'(e_qj));
        chk("out_qk", 128'(out_qk), 128'(e_qk));
        chk("out_dest", 128'(out_dest), 128'(e_dest));
        chk("out_rd", 128'(out_rd), 128'(e_rd));
        chk("out_payload", out_payload, e_pl);
    endtask

    // One clock cycle: drive, check in_ready before the edge, update model, check outputs after.
    task automatic step(input bit v, input int rd, input bit wen, input int rs1, input int rs2,
                        input bit ordy, input bit cmt, input bit fl, input bit rst);
        logic [127:0] pl;
        bit exp_rdy, cv, acc;
        int cd, crd, qj, qk;
        pl = {$urandom, $urandom, $urandom, $urandom};
        cv = cmt && (m_rob.size() > 0);
        cd = cv ? m_rob[0].tag : 0;
        crd = cv ? m_rob[0].rd : 0;
        reset = rst; in_valid = v; in_rd = RLEN'(rd); in_rd_wen = wen;
        in_rs1 = RLEN'(rs1); in_rs2 = RLEN'(rs2); in_payload = pl; out_ready = ordy;
        cmt_valid = cv; cmt_dest = TW'(cd); cmt_rd = RLEN'(crd); flush = fl;
        #1;
        exp_rdy = (!e_ov || ordy) && (m_rob.size() < ROB) && !fl;
        chk("in_ready", 128'(in_ready), 128'(exp_rdy));
        @(posedge clock);
        if (!rst) begin
            model_clear(1);
        end else if (fl) begin
            model_clear(0);
        end else begin
            acc = v && exp_rdy;
            qj = look(rs1, cv, cd);
            qk = look(rs2, cv, cd);
            if (cv) begin
                void'(m_rob.pop_front());
                if (crd != 0 && m_map[crd] == cd) m_map[crd] = 0;
            end
            if (acc) begin
                e_ov = 1; e_dest = m_tail + 1; e_qj = qj; e_qk = qk;
                e_rd = wen ? rd : 0; e_pl = pl;
                if (wen && rd != 0) m_map[rd] = m_tail + 1;
                m_rob.push_back('{tag: m_tail + 1, rd: (wen ? rd : 0)});
                m_tail = (m_tail + 1) % ROB;
            end else if (ordy) begin
                e_ov = 0;
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0, 0);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        model_clear(1);
        @(posedge clock);
        #1;

        // Reset state and first rename / dependency chain
        do_reset();
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        step(1, 5, 1, 1, 2, 1, 0, 0, 1);
        chk("t1_dest", 128'(out_dest), 128'(1));
        chk("t1_qj", 128'(out_qj), 128'(0));
        step(1, 6, 1, 5, 5, 1, 0, 0, 1);
        chk("t2_qj", 128'(out_qj), 128'(1));
        chk("t2_qk", 128'(out_qk), 128'(1));
        chk("t2_dest", 128'(out_dest), 128'(2));
        step(0, 0, 0, 0, 0, 1, 1, 0, 1);
        step(1, 7, 1, 5, 0, 1, 0, 0, 1);
        chk("t2_map5_cleared", 128'(out_qj), 128'(0));

        // Same-cycle retire bypass on read
        do_reset();
        step(1, 5, 1, 0, 0, 1, 0, 0, 1);
        step(1, 7, 1, 5, 0, 1, 1, 0, 1);
        chk("t3_bypass_qj", 128'(out_qj), 128'(0));

        // Same-cycle retire vs rename of the same rd: newer mapping wins
        do_reset();
        step(1, 5, 1, 0, 0, 1, 0, 0, 1);
        step(1, 5, 1, 0, 0, 1, 1, 0, 1);
        step(1, 8, 1, 5, 0, 1, 0, 0, 1);
        chk("t3_newer_kept", 128'(out_qj), 128'(2));

        // Fill the ROB, stall, then free one entry and see tail wrap
        do_reset();
        for (int i = 0; i < ROB; i++) step(1, i + 1, 1, i, 0, 1, 0, 0, 1);
        step(1, 9, 1, 1, 2, 1, 0, 0, 1);
        chk("t4_full_ready", 128'(in_ready), 128'(0));
        step(0, 0, 0, 0, 0, 1, 1, 0, 1);
        step(1, 9, 1, 1, 2, 1, 0, 0, 1);
        chk("t4_wrap_dest", 128'(out_dest), 128'(1));

        // Backpressure: bundle frozen for 3 cycles
        do_reset();
        step(1, 3, 1, 0, 0, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 4, 1, 3, 3, 0, 0, 0, 1);
        chk("t5_frozen_dest", 128'(out_dest), 128'(1));
        step(1, 4, 1, 3, 3, 1, 0, 0, 1);
        chk("t5_resume_dest", 128'(out_dest), 128'(2));

        // Flush with in-flight work, then reset mid-stream
        do_reset();
        for (int i = 0; i < 3; i++) step(1, i + 1, 1, 0, 0, 1, 0, 0, 1);
        step(1, 9, 1, 1, 2, 1, 0, 1, 1);
        chk("t6_flush_valid", 128'(out_valid), 128'(0));
        step(1, 4, 1, 1, 2, 1, 0, 0, 1);
        chk("t6_flush_dest", 128'(out_dest), 128'(1));
        chk("t6_flush_map", 128'({out_qj, out_qk}), 128'(0));
        for (int i = 0; i < 3; i++) step(1, i + 1, 1, 0, 0, 1, 0, 0, 1);
        step(1, 9, 1, 1, 2, 1, 0, 0, 0);
        chk("t6_rst_valid", 128'(out_valid), 128'(0));
        step(1, 4, 1, 1, 2, 1, 0, 0, 1);
        chk("t6_rst_dest", 128'(out_dest), 128'(1));

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            step(($urandom % 4) != 0, int'($urandom % 8), ($urandom % 4) != 0,
                 int'($urandom % 8), int'($urandom % 8), ($urandom % 4) != 0,
                 ($urandom % 3) == 0, ($urandom % 50) == 0, ($urandom % 80) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
